fetch_inst_buffer: RTL and testbench

- Decoupling instruction queue between the fetch stage and the backend rename/dispatch input.
- Accepts up to FETCH_WIDTH fetched entries per cycle, compacts sparse valid lanes, and presents up to FETCH_WIDTH oldest entries per cycle in program order.
- The backend stall signal holds the output; a squash from the backend empties the queue.

---
 rtl/fetch_inst_buffer.sv | 153 +++++++++++++++
 tb/tb_fetch_inst_buffer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_inst_buffer.sv
// fetch_inst_buffer: compacting fetch-to-dispatch instruction queue.
// Define IBUF_BYPASS_EN for a zero-latency empty-queue bypass path.
module fetch_inst_buffer #(
  parameter int FETCH_WIDTH = 4,
  parameter int DEPTH       = 16,
  parameter int ENTRY_W     = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_squash_vld,
  input  logic [FETCH_WIDTH-1:0]         i_enq_vld,
  input  logic [FETCH_WIDTH*ENTRY_W-1:0] i_enq_data,
  output logic                           o_enq_ready,
  input  logic                           i_deq_stall,
  output logic [FETCH_WIDTH-1:0]         o_deq_vld,
  output logic [FETCH_WIDTH*ENTRY_W-1:0] o_deq_data,
  output logic [$clog2(DEPTH):0]         o_count
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
`ifdef IBUF_BYPASS_EN
  localparam int CW = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
`endif

  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] FW_P    = PW'(FETCH_WIDTH);
  localparam logic [PW-1:0] LIM_P   = PW'(DEPTH - FETCH_WIDTH);

  logic [ENTRY_W-1:0] mem_q [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;

  logic [PW-1:0] count;
  logic [PW-1:0] n_deq;
  logic [PW-1:0] enq_cnt;
  logic [IW-1:0] wr_idx [FETCH_WIDTH];
  logic          enq_fire;
  logic          bypass_hit;

`ifdef IBUF_BYPASS_EN
  logic [ENTRY_W-1:0] byp_data [FETCH_WIDTH];
`endif

  assign count       = tail_q - head_q;
  assign o_count     = count;
  assign o_enq_ready = (DEPTH_P - count) >= FW_P;
  assign n_deq       = (count >= FW_P) ? FW_P : count;

`ifdef IBUF_BYPASS_EN
  assign bypass_hit = (count == '0) && !i_squash_vld &&
                      !i_deq_stall && (|i_enq_vld);
`else
  assign bypass_hit = 1'b0;
`endif

  assign enq_fire = o_enq_ready && (|i_enq_vld) &&
                    !i_squash_vld && !bypass_hit;

  // Compact sparse lanes: each valid lane gets the next free slot
  always_comb begin
    enq_cnt = '0;
`ifdef IBUF_BYPASS_EN
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      byp_data[i] = '0;
    end
`endif
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      wr_idx[i] = tail_q[IW-1:0] + enq_cnt[IW-1:0];
      if (i_enq_vld[i]) begin
`ifdef IBUF_BYPASS_EN
        byp_data[enq_cnt[CW-1:0]] =
          i_enq_data[i*ENTRY_W +: ENTRY_W];
`endif
        enq_cnt = enq_cnt + PW'(1);
      end
    end
  end

  // Present the oldest group; squash hides it
  always_comb begin
    o_deq_vld  = '0;
    o_deq_data = '0;
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      o_deq_vld[k] = n_deq > PW'(k);
      o_deq_data[k*ENTRY_W +: ENTRY_W] =
        mem_q[head_q[IW-1:0] + IW'(k)];
    end
`ifdef IBUF_BYPASS_EN
    if (bypass_hit) begin
      for (int k = 0; k < FETCH_WIDTH; k++) begin
        o_deq_vld[k] = enq_cnt > PW'(k);
        o_deq_data[k*ENTRY_W +: ENTRY_W] = byp_data[k];
      end
    end
`endif
    if (i_squash_vld) begin
      o_deq_vld = '0;
    end
  end

  // Pointer next-state: squash wins, else enqueue and dequeue together
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    unique case (1'b1)
      i_squash_vld: begin
        head_d = '0;
        tail_d = '0;
      end
      default: begin
        if (enq_fire) begin
          tail_d = tail_q + enq_cnt;
        end
        if (!i_deq_stall) begin
          head_d = head_q + n_deq;
        end
      end
    endcase
  end

  // Pointer registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // Compacted lane writes; storage contents need no reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (enq_fire && i_enq_vld[i]) begin
        mem_q[wr_idx[i]] <= i_enq_data[i*ENTRY_W +: ENTRY_W];
      end
    end
  end

`ifndef SYNTHESIS
  // Occupancy sanity checks
  always_ff @(posedge clk) begin
    if (rst) begin
      assert (!(enq_fire && (count > LIM_P)));
      assert (count <= DEPTH_P);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_inst_buffer.sv
// tb_fetch_inst_buffer: queue-model check of fetch_inst_buffer.
// Directed latency checks apply to the default (no bypass) build.
module tb_fetch_inst_buffer;

  localparam int FW    = 4;
  localparam int DEPTH = 16;
  localparam int EW    = 64;
  localparam int PW    = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              sq = 1'b0;
  logic              stall = 1'b0;
  logic [FW-1:0]     vld = '0;
  logic [FW*EW-1:0]  data = '0;
  logic              rdy;
  logic [FW-1:0]     dvld;
  logic [FW*EW-1:0]  ddata;
  logic [PW-1:0]     cnt;

  int tests = 0;
  int fails = 0;

  logic [EW-1:0] mq [$];

  always #5 clk = ~clk;

  fetch_inst_buffer #(
    .FETCH_WIDTH(FW),
    .DEPTH(DEPTH),
    .ENTRY_W(EW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_squash_vld(sq),
    .i_enq_vld(vld),
    .i_enq_data(data),
    .o_enq_ready(rdy),
    .i_deq_stall(stall),
    .o_deq_vld(dvld),
    .o_deq_data(ddata),
    .o_count(cnt)
  );

  task automatic check(input string nm,
                       input logic [EW-1:0] got,
                       input logic [EW-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  function automatic bit byp_now();
`ifdef IBUF_BYPASS_EN
    return (mq.size() == 0) && !sq && !stall && (|vld);
`else
    return 1'b0;
`endif
  endfunction

  // Reference queue: pop the oldest group, append valid lanes in order
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
    end else if (sq) begin
      mq.delete();
    end else if (!byp_now()) begin
      automatic int n = (mq.size() < FW) ? mq.size() : FW;
      automatic bit take = ((DEPTH - mq.size()) >= FW) && (|vld);
      if (!stall) begin
        for (int j = 0; j < n; j++) void'(mq.pop_front());
      end
      if (take) begin
        for (int i = 0; i < FW; i++) begin
          if (vld[i]) mq.push_back(data[i*EW +: EW]);
        end
      end
    end
  end

  // Compare DUT outputs against the queue model every cycle
  always @(negedge clk) begin
    automatic int n = (mq.size() < FW) ? mq.size() : FW;
    automatic logic [FW-1:0] ev = '0;
    automatic logic [EW-1:0] ed [FW];
    for (int k = 0; k < FW; k++) begin
      ev[k] = (k < n);
      ed[k] = (k < n) ? mq[k] : '0;
    end
    if (byp_now()) begin
      automatic int p = 0;
      ev = '0;
      for (int i = 0; i < FW; i++) begin
        if (vld[i]) begin
          ev[p] = 1'b1;
          ed[p] = data[i*EW +: EW];
          p++;
        end
      end
    end
    if (sq) ev = '0;
    check("count", EW'(cnt), EW'(mq.size()));
    check("enq_ready", EW'(rdy), EW'((DEPTH - mq.size()) >= FW));
    check("deq_vld", EW'(dvld), EW'(ev));
    for (int k = 0; k < FW; k++) begin
      if (ev[k]) begin
        check($sformatf("lane%0d", k), ddata[k*EW +: EW], ed[k]);
      end
    end
  end

  task automatic step(input bit s, input logic [FW-1:0] v, input bit st);
    sq = s;
    vld = v;
    stall = st;
    for (int i = 0; i < FW; i++) begin
      data[i*EW +: EW] = {$urandom, $urandom};
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [EW-1:0] lane(input logic [FW*EW-1:0] d,
                                         input int i);
    return d[i*EW +: EW];
  endfunction

  initial begin
    logic [FW*EW-1:0] w;
    logic [FW*EW-1:0] x;
    int sth;
    rst = 1'b0;
    #3;
    check("rst_vld", EW'(dvld), 64'h0);
    check("rst_rdy", EW'(rdy), 64'h1);
    check("rst_cnt", EW'(cnt), 64'h0);
    #20;
    rst = 1'b1;
    @(posedge clk);
    #1;
    step(0, 4'h0, 1);
    check("idle_cnt", EW'(cnt), 64'd0);
    check("idle_vld", EW'(dvld), 64'h0);

`ifndef IBUF_BYPASS_EN
    step(0, 4'hF, 0);
    check("full_vld", EW'(dvld), 64'hF);
    check("full_cnt", EW'(cnt), 64'd4);
    for (int k = 0; k < FW; k++) begin
      check("full_lane", lane(ddata, k), lane(data, k));
    end
    step(0, 4'h0, 0);
    check("drain_cnt", EW'(cnt), 64'd0);
    check("drain_vld", EW'(dvld), 64'h0);

    step(0, 4'b0101, 1);
    check("sparse_vld", EW'(dvld), 64'h3);
    check("sparse_cnt", EW'(cnt), 64'd2);
    check("sparse_l0", lane(ddata, 0), lane(data, 0));
    check("sparse_l1", lane(ddata, 1), lane(data, 2));
    step(0, 4'h0, 0);
    check("sparse_drain", EW'(cnt), 64'd0);

    repeat (3) step(0, 4'hF, 1);
    check("fill12_cnt", EW'(cnt), 64'd12);
    check("fill12_rdy", EW'(rdy), 64'h1);
    step(0, 4'hF, 1);
    check("fill16_cnt", EW'(cnt), 64'd16);
    check("fill16_rdy", EW'(rdy), 64'h0);
    step(0, 4'hF, 1);
    check("full_hold", EW'(cnt), 64'd16);
    repeat (4) step(0, 4'h0, 0);
    check("empty_cnt", EW'(cnt), 64'd0);

    repeat (2) step(0, 4'hF, 1);
    repeat (2) step(0, 4'h0, 0);
    check("at14_cnt", EW'(cnt), 64'd0);
    step(0, 4'hF, 1);
    w = data;
    check("wrap_cnt", EW'(cnt), 64'd4);
    step(0, 4'hF, 1);
    x = data;
    check("wrap_cnt8", EW'(cnt), 64'd8);
    for (int k = 0; k < FW; k++) begin
      check("wrap_w", lane(ddata, k), lane(w, k));
    end
    step(0, 4'h0, 0);
    check("wrap_cnt4", EW'(cnt), 64'd4);
    for (int k = 0; k < FW; k++) begin
      check("wrap_x", lane(ddata, k), lane(x, k));
    end
    step(0, 4'h0, 0);

    step(0, 4'hF, 1);
    step(0, 4'b0111, 1);
    check("pre_sq_cnt", EW'(cnt), 64'd7);
    sq = 1'b1;
    vld = 4'hF;
    stall = 1'b0;
    #1;
    check("sq_vld", EW'(dvld), 64'h0);
    @(posedge clk);
    #1;
    check("sq_cnt", EW'(cnt), 64'd0);
    step(0, 4'h0, 1);
    check("post_sq_cnt", EW'(cnt), 64'd0);
    check("post_sq_vld", EW'(dvld), 64'h0);

    step(0, 4'hF, 1);
    step(0, 4'hF, 1);
    step(0, 4'h1, 1);
    check("pre_rst_cnt", EW'(cnt), 64'd9);
    vld = 4'h0;
    #2;
    rst = 1'b0;
    #1;
    check("arst_vld", EW'(dvld), 64'h0);
    check("arst_rdy", EW'(rdy), 64'h1);
    check("arst_cnt", EW'(cnt), 64'd0);
    #3;
    rst = 1'b1;
    @(posedge clk);
    #1;
`endif

    for (int ph = 0; ph < 6; ph++) begin
      sth = (ph % 3 == 0) ? 2 : ((ph % 3 == 1) ? 7 : 9);
      repeat (500) begin
        step($urandom_range(0, 29) == 0,
             FW'($urandom),
             $urandom_range(0, 9) < sth);
      end
    end
    step(0, 4'h0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
